// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter / fetch unit.
// Holds the fetch FSM state encoding, the NOP instruction value and the
// next-PC source encoding with its priority encoder.
package pc_pkg;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } pc_state_t;

   // Source of the next program counter
   typedef enum logic [1:0] {
      SEL_SEQ    = 2'd0,
      SEL_BRANCH = 2'd1,
      SEL_JUMP   = 2'd2
   } next_sel_t;

   // Instruction presented to decode while nothing has been fetched yet
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Redirect priority: an absolute jump beats a taken branch, which beats
   // sequential flow.
   function automatic next_sel_t next_sel_encode(input logic jump,
                                                 input logic branch_taken);
      if (jump) begin
         return SEL_JUMP;
      end else if (branch_taken) begin
         return SEL_BRANCH;
      end else begin
         return SEL_SEQ;
      end
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority multiplexer.
// Chooses between the sequential successor, the branch-adder target and the
// absolute jump target. Purely combinational; sampling is done by the caller.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] PCp1,
   input  logic [AW-1:0] PCBranch,
   input  logic [AW-1:0] jump_target,
   input  logic          branch_taken,
   input  logic          jump,
   output logic [AW-1:0] next_pc
);

   next_sel_t sel;

   // Encode which source wins this cycle
   always_comb begin
      sel = next_sel_encode(jump, branch_taken);
   end

   // Route the selected source to the output
   always_comb begin
      next_pc = PCp1;
      case (sel)
         SEL_JUMP:   next_pc = jump_target;
         SEL_BRANCH: next_pc = PCBranch;
         SEL_SEQ:    next_pc = PCp1;
         default:    next_pc = PCp1;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// BOOT -> FETCH (req/ack to instruction memory) -> EXEC (one instruction
// presented to the core) -> FETCH ..., with stall, halt and jump/branch
// redirection applied only while an instruction is executing.
// Optional feature macro PC_PERF_CNT_EN adds retired/redirect counters.
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter logic [AW-1:0]   RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [DW-1:0] imem_rdata,
   output logic [DW-1:0] instr,
   output logic          instr_valid,
   output logic [AW-1:0] PC,
   output logic [AW-1:0] PCp1,
   input  logic [AW-1:0] PCBranch,
   input  logic          branch_taken,
   input  logic          jump,
   input  logic [AW-1:0] jump_target,
   input  logic          stall,
   input  logic          halt,
   output logic          halted
`ifdef PC_PERF_CNT_EN
   ,
   output logic [31:0]   retired_cnt,
   output logic [31:0]   redirect_cnt
`endif
);

   localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] NOP_WORD = DW'(NOP_INSTR);

   pc_state_t     state_reg;
   pc_state_t     state_next;
   logic [AW-1:0] pc_reg;
   logic [AW-1:0] pc_plus_one;
   logic [AW-1:0] next_pc;
   logic [DW-1:0] instr_reg;
   logic          fetch_done;
   logic          exec_leave;
   logic          exec_advance;

   // Sequential successor, wrapping at 2^AW (word addressed)
   always_comb begin
      pc_plus_one = pc_reg + PC_ONE;
   end

   pc_next_sel #(
      .AW (AW)
   ) u_next_sel (
      .PCp1         (pc_plus_one),
      .PCBranch     (PCBranch),
      .jump_target  (jump_target),
      .branch_taken (branch_taken),
      .jump         (jump),
      .next_pc      (next_pc)
   );

   // Qualified events: a completed fetch, and leaving EXEC (to FETCH or HALT)
   always_comb begin
      fetch_done   = (state_reg == FETCH) && imem_ack;
      exec_leave   = (state_reg == EXEC) && !stall;
      exec_advance = exec_leave && !halt;
   end

   // Next-state logic for the fetch sequencer; stall outranks halt
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         BOOT: begin
            state_next = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (!stall) begin
               state_next = halt ? HALT : FETCH;
            end
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   // State register; reset returns to BOOT immediately, dropping any fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= BOOT;
      end else begin
         state_reg <= state_next;
      end
   end

   // Program counter: only moves when an executing instruction retires forward
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg <= RESET_PC;
      end else if (exec_advance) begin
         pc_reg <= next_pc;
      end
   end

   // Instruction latch: captures returned data, otherwise keeps the last word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_reg <= NOP_WORD;
      end else if (fetch_done) begin
         instr_reg <= imem_rdata;
      end
   end

   // Outputs decoded directly from state so reset takes effect without a clock
   always_comb begin
      imem_req    = (state_reg == FETCH);
      imem_addr   = pc_reg;
      instr       = instr_reg;
      instr_valid = (state_reg == EXEC);
      halted      = (state_reg == HALT);
      PC          = pc_reg;
      PCp1        = pc_plus_one;
   end

`ifdef PC_PERF_CNT_EN
   logic [31:0] retired_cnt_reg;
   logic [31:0] redirect_cnt_reg;

   // Retired count bumps on every EXEC exit; redirect count only when the
   // exit actually follows a jump or taken branch (halt keeps PC in place)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt_reg  <= 32'd0;
         redirect_cnt_reg <= 32'd0;
      end else if (exec_leave) begin
         retired_cnt_reg <= retired_cnt_reg + 32'd1;
         if (exec_advance && (jump || branch_taken)) begin
            redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
         end
      end
   end

   // Counter outputs
   always_comb begin
      retired_cnt  = retired_cnt_reg;
      redirect_cnt = redirect_cnt_reg;
   end
`endif

endmodule
